// File: rtl/cell_share_arbiter.sv
// Round-robin sequencer that time-shares one 2-input logic cell among NREQ
// requesters: latch a winner's operand pair, drive the cell, capture and return the result.
module cell_share_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op_a,
  input  logic [NREQ-1:0] op_b,
  output logic [NREQ-1:0] gnt,
  output logic            cell_a,
  output logic            cell_b,
  output logic            cell_vld,
  input  logic            cell_out,
  output logic [NREQ-1:0] rsp_vld,
  output logic            rsp_data,
  output logic            busy
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic            opa_q, opa_d;
  logic            opb_q, opb_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_vld_q, rsp_vld_d;
  logic            cell_a_q, cell_a_d;
  logic            cell_b_q, cell_b_d;
  logic            cell_vld_q, cell_vld_d;
  logic            rsp_data_q, rsp_data_d;
  logic            busy_q, busy_d;
  logic            sel_found_s;
  logic [PW-1:0]   sel_idx_s;
  logic [NREQ-1:0] win_oh_s;

  // Round-robin pick: first requesting index at or above ptr, wrapping.
  always_comb begin
    logic [PW-1:0] idx_v;
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v = PW'((int'(ptr_q) + k) % NREQ);
      if (!sel_found_s && req[idx_v]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = idx_v;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Sequencer next state, winner/operand latching and pointer advance.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ena && sel_found_s) begin
          win_d   = sel_idx_s;
          opa_d   = op_a[sel_idx_s];
          opb_d   = op_b[sel_idx_s];
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (LAT == 0) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 3'(LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (int'(win_q) == NREQ - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = win_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign win_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << win_d;

  // Output values for the upcoming state; entering RESP is the capture edge.
  always_comb begin
    gnt_d      = '0;
    rsp_vld_d  = '0;
    cell_a_d   = 1'b0;
    cell_b_d   = 1'b0;
    cell_vld_d = 1'b0;
    rsp_data_d = 1'b0;
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_ISSUE: begin
        gnt_d      = win_oh_s;
        cell_vld_d = 1'b1;
        cell_a_d   = opa_d;
        cell_b_d   = opb_d;
      end
      S_WAIT: begin
        cell_vld_d = 1'b1;
        cell_a_d   = opa_d;
        cell_b_d   = opb_d;
      end
      S_RESP: begin
        rsp_vld_d  = win_oh_s;
        rsp_data_d = cell_out;
      end
      default: begin
        busy_d = busy_d;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      opa_q      <= 1'b0;
      opb_q      <= 1'b0;
      cnt_q      <= 3'd0;
      gnt_q      <= '0;
      rsp_vld_q  <= '0;
      cell_a_q   <= 1'b0;
      cell_b_q   <= 1'b0;
      cell_vld_q <= 1'b0;
      rsp_data_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      rsp_vld_q  <= rsp_vld_d;
      cell_a_q   <= cell_a_d;
      cell_b_q   <= cell_b_d;
      cell_vld_q <= cell_vld_d;
      rsp_data_q <= rsp_data_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt      = gnt_q;
  assign rsp_vld  = rsp_vld_q;
  assign cell_a   = cell_a_q;
  assign cell_b   = cell_b_q;
  assign cell_vld = cell_vld_q;
  assign rsp_data = rsp_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_cell_share_arbiter.sv
// Bench for cell_share_arbiter: LAT=0 and LAT=2 instances on shared inputs,
// vector table, transaction-timeline reference model and corner-case sequences.
module tb_cell_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [3:0] req, op_a, op_b;
  logic [3:0] gnt0, rv0, gnt2, rv2;
  logic       ca0, cb0, cv0, co0, rd0, bz0;
  logic       ca2, cb2, cv2, co2, rd2, bz2;
  logic       force_en, force_val;
  logic [12:0] got0, got2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cell_share_arbiter #(.NREQ(4), .LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt0), .cell_a(ca0), .cell_b(cb0), .cell_vld(cv0), .cell_out(co0),
    .rsp_vld(rv0), .rsp_data(rd0), .busy(bz0));

  cell_share_arbiter #(.NREQ(4), .LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt2), .cell_a(ca2), .cell_b(cb2), .cell_vld(cv2), .cell_out(co2),
    .rsp_vld(rv2), .rsp_data(rd2), .busy(bz2));

  // Shared cell is an AND gate; the LAT=2 cell can be overridden to probe capture timing.
  assign co0  = ca0 & cb0;
  assign co2  = force_en ? force_val : (ca2 & cb2);
  assign got0 = {gnt0, cv0, ca0, cb0, rv0, rd0, bz0};
  assign got2 = {gnt2, cv2, ca2, cb2, rv2, rd2, bz2};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: transaction timeline ----------------
  bit m_act[2];
  int m_t[2], m_win[2], m_ptr[2];
  bit m_a[2], m_b[2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_act[m] = 0; m_t[m] = 0; m_win[m] = 0; m_ptr[m] = 0; m_a[m] = 0; m_b[m] = 0;
    end
  endtask

  task automatic model_edge(input int m, input int lat);
    bit found;
    int idx;
    found = 0;
    if (m_act[m]) begin
      if (m_t[m] == 2 + lat) begin
        m_act[m] = 0;
        m_ptr[m] = (m_win[m] + 1) % 4;
      end else begin
        m_t[m]++;
      end
    end else if (ena && req != 4'd0) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr[m] + k) % 4;
        if (!found && req[idx]) begin
          found = 1; m_win[m] = idx; m_a[m] = op_a[idx]; m_b[m] = op_b[idx];
          m_act[m] = 1; m_t[m] = 1;
        end
      end
    end
  endtask

  function automatic logic [12:0] model_exp(input int m, input int lat);
    logic [3:0] oh, g, r;
    logic cv, rd;
    oh = 4'(1 << m_win[m]);
    g  = (m_act[m] && m_t[m] == 1) ? oh : 4'd0;
    cv = m_act[m] && (m_t[m] <= 1 + lat);
    r  = (m_act[m] && m_t[m] == 2 + lat) ? oh : 4'd0;
    rd = (r != 4'd0) && m_a[m] && m_b[m];
    return {g, cv, cv & m_a[m], cv & m_b[m], r, rd, m_act[m]};
  endfunction

  // ---------------- vector table (LAT=0 instance) ----------------
  typedef struct {
    bit rst; bit en; logic [3:0] rq, a, b;
    logic [12:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input bit rst, input bit en, input logic [3:0] rq, a, b,
                             input logic [3:0] g, input bit cv, ca, cb,
                             input logic [3:0] rv, input bit rd, bz);
    vec_t x;
    x.rst = rst; x.en = en; x.rq = rq; x.a = a; x.b = b;
    x.exp = {g, cv, ca, cb, rv, rd, bz};
    return x;
  endfunction

  int fair_exp[4] = '{0, 2, 0, 2};
  int ngr, cv_cnt, rsp_cyc;
  logic rdv, any_g, seen;

  initial begin
    rst_n = 1'b0; ena = 1'b0; req = 4'd0; op_a = 4'd0; op_b = 4'd0;
    force_en = 1'b0; force_val = 1'b0;

    // single request, then all four held (op_b=0101), then ena gating
    tbl.push_back(v(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 4'h1, 4'h1, 4'h1, 4'h1, 1, 1, 1, 4'h0, 0, 1));
    tbl.push_back(v(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h1, 1, 1));
    tbl.push_back(v(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(v(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h1, 1, 1, 1, 4'h0, 0, 1));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h0, 0, 0, 0, 4'h1, 1, 1));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h0, 0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h2, 1, 1, 0, 4'h0, 0, 1));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h0, 0, 0, 0, 4'h2, 0, 1));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h0, 0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h4, 1, 1, 1, 4'h0, 0, 1));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h0, 0, 0, 0, 4'h4, 1, 1));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h0, 0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h8, 1, 1, 0, 4'h0, 0, 1));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h0, 0, 0, 0, 4'h8, 0, 1));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h0, 0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h1, 1, 1, 1, 4'h0, 0, 1));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h0, 0, 0, 0, 4'h1, 1, 1));
    tbl.push_back(v(0, 0, 4'hF, 4'hF, 4'h5, 4'h0, 0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(v(0, 0, 4'hF, 4'hF, 4'h5, 4'h0, 0, 0, 0, 4'h0, 0, 0));
    tbl.push_back(v(0, 1, 4'hF, 4'hF, 4'h5, 4'h2, 1, 1, 0, 4'h0, 0, 1));

    repeat (2) @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = !tbl[i].rst; ena = tbl[i].en; req = tbl[i].rq; op_a = tbl[i].a; op_b = tbl[i].b;
      @(negedge clk);
      chk($sformatf("table_row%0d", i), 32'(got0), 32'(tbl[i].exp));
    end

    // randomized traffic on both instances against the timeline model
    rst_n = 1'b0; req = 4'd0; model_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      chk("rand_lat0", 32'(got0), 32'(model_exp(0, 0)));
      chk("rand_lat2", 32'(got2), 32'(model_exp(1, 2)));
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
        req  = 4'($urandom_range(0, 15));
        op_a = 4'($urandom_range(0, 15));
        op_b = 4'($urandom_range(0, 15));
        ena  = ($urandom_range(0, 3) != 0);
        model_edge(0, 0);
        model_edge(1, 2);
      end
    end

    // fairness: req=0101 held from reset
    rst_n = 1'b0; req = 4'd0; ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; ena = 1'b1; req = 4'b0101; op_a = 4'd0; op_b = 4'd0;
    ngr = 0;
    for (int c = 0; c < 40 && ngr < 4; c++) begin
      @(negedge clk);
      if (gnt0 != 4'd0) begin
        chk("fair_gnt", 32'(gnt0), 32'(4'(1 << fair_exp[ngr])));
        ngr++;
      end
    end
    chk("fair_grant_count", 32'(ngr), 32'd4);

    // LAT=2 capture point: cell_out differs only at the final WAIT edge
    rst_n = 1'b0; req = 4'd0;
    @(negedge clk);
    rst_n = 1'b1; force_en = 1'b1;
    for (int tr = 0; tr < 2; tr++) begin
      rdv = 1'b0; cv_cnt = 0; rsp_cyc = 0;
      req = 4'b0001; op_a = 4'b0001; op_b = 4'b0001; force_val = (tr == 0) ? 1'b0 : 1'b1;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        req = 4'd0;
        if (cv2) cv_cnt++;
        if (rv2 != 4'd0) begin rsp_cyc = c; rdv = rd2; end
        force_val = (c == 3) ? (tr == 0) : (tr != 0);
      end
      chk("lat2_cell_vld_cycles", 32'(cv_cnt), 32'd3);
      chk("lat2_rsp_cycle", 32'(rsp_cyc), 32'd4);
      chk("lat2_capture", 32'(rdv), (tr == 0) ? 32'd1 : 32'd0);
    end
    force_en = 1'b0;

    // ena gating, then ena dropped during the transaction
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; ena = 1'b0; req = 4'b0010; any_g = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (gnt0 != 4'd0 || gnt2 != 4'd0 || bz0 || bz2) any_g = 1'b1;
    end
    chk("ena_blocks_grant", 32'(any_g), 32'd0);
    ena = 1'b1;
    @(negedge clk);
    chk("ena_gnt_lat0", 32'(gnt0), 32'h2);
    chk("ena_gnt_lat2", 32'(gnt2), 32'h2);
    ena = 1'b0; req = 4'd0; seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rv2 == 4'b0010) seen = 1'b1;
    end
    chk("ena_drop_rsp", 32'(seen), 32'd1);

    // reset during WAIT loses the transaction and clears ptr
    ena = 1'b1; req = 4'b0100;
    @(negedge clk);
    req = 4'd0;
    repeat (6) @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'd0;
    @(negedge clk);
    chk("pre_reset_in_wait", 32'({cv2, bz2, gnt2}), 32'({1'b1, 1'b1, 4'd0}));
    rst_n = 1'b0;
    #1;
    chk("reset_async_outputs", 32'(got2), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rv2 != 4'd0 || got2 != 13'd0) seen = 1'b1;
    end
    chk("reset_no_rsp", 32'(seen), 32'd0);
    rst_n = 1'b1; req = 4'b1001;
    @(negedge clk);
    chk("reset_ptr_gnt", 32'(gnt2), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
